// File: rtl/img_frame_buffer.sv
// img_frame_buffer: ping-pong 16x16 pixel buffer feeding the nn feedforward block.
//
// Write side takes a valid/ready pixel stream with a start-of-frame marker and fills
// the current write bank. The read side exposes the oldest complete frame through a
// zero-latency address/data port; addresses past the last pixel return the bias value.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pix_valid/pix_sof/pix_data, pix_ready   pixel stream in (valid/ready)
//   rd_adr, rd_data       combinational read port into the read bank
//   frame_avail           read bank holds a complete frame
//   frame_release         pulse: read bank consumed, advance to the next frame
//   drop_cnt              saturating count of abandoned partial frames
module img_frame_buffer #(
    parameter int unsigned       PIX_W    = 8,
    parameter int unsigned       NUM_PIX  = 256,
    parameter int unsigned       ADR_LEN  = 9,
    parameter logic [PIX_W-1:0]  BIAS_VAL = {PIX_W{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_valid,
    input  logic                pix_sof,
    input  logic [PIX_W-1:0]    pix_data,
    output logic                pix_ready,
    input  logic [ADR_LEN-1:0]  rd_adr,
    output logic [PIX_W-1:0]    rd_data,
    output logic                frame_avail,
    input  logic                frame_release,
    output logic [7:0]          drop_cnt
);

    localparam int unsigned CNT_W  = $clog2(NUM_PIX);
    localparam int unsigned DROP_W = 8;

    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [1:0]         full_q, full_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic               synced_q, synced_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic               accept_c;
    logic               wr_en_c;
    logic [CNT_W-1:0]   wr_idx_c;
    logic               rd_hit_c;

    logic [PIX_W-1:0]   mem [2][NUM_PIX];

    // Flags depend on registers only, so ready/avail never follow valid or release.
    assign pix_ready   = ~full_q[wr_bank_q];
    assign frame_avail = full_q[rd_bank_q];
    assign drop_cnt    = drop_cnt_q;
    assign accept_c    = pix_valid & pix_ready;

    // Next-state: write-side sync/fill and read-side release.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        wr_cnt_d   = wr_cnt_q;
        synced_d   = synced_q;
        drop_cnt_d = drop_cnt_q;
        wr_en_c    = 1'b0;
        wr_idx_c   = wr_cnt_q;

        if (accept_c) begin
            if (pix_sof) begin
                // A sof mid-frame abandons the partial frame and restarts at pixel 0.
                if (synced_q && (wr_cnt_q != '0) && (drop_cnt_q != {DROP_W{1'b1}})) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
                wr_en_c  = 1'b1;
                wr_idx_c = '0;
                wr_cnt_d = CNT_W'(1);
                synced_d = 1'b1;
            end else if (synced_q) begin
                wr_en_c = 1'b1;
                if (wr_cnt_q == CNT_W'(NUM_PIX - 1)) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_cnt_d          = '0;
                    synced_d          = 1'b0;
                end else begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end
        end

        // Release never touches the bank being filled: accept implies it is empty.
        if (frame_release && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            wr_cnt_q   <= '0;
            synced_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            wr_cnt_q   <= wr_cnt_d;
            synced_q   <= synced_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Pixel storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_bank_q][wr_idx_c] <= pix_data;
        end
    end

    // Zero-latency read; out-of-frame addresses return the bias row value.
    assign rd_hit_c = (rd_adr < ADR_LEN'(NUM_PIX));
    assign rd_data  = rd_hit_c ? mem[rd_bank_q][rd_adr[CNT_W-1:0]] : BIAS_VAL;

endmodule

// File: tb/tb_img_frame_buffer.sv
// Directed bench for img_frame_buffer. Frame k carries pixel i = i ^ key, so the
// expected value at any address is computed by hand from the key.
module tb_img_frame_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_ready;
    logic [8:0]  rd_adr = 9'h000;
    logic [7:0]  rd_data;
    logic        frame_avail;
    logic        frame_release = 1'b0;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    img_frame_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .pix_valid     (pix_valid),
        .pix_sof       (pix_sof),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .rd_adr        (rd_adr),
        .rd_data       (rd_data),
        .frame_avail   (frame_avail),
        .frame_release (frame_release),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [8:0] adr, input logic [7:0] exp);
        rd_adr = adr;
        #1;
        check(tag, 16'(rd_data), 16'(exp));
    endtask

    task automatic do_reset();
        pix_valid     = 1'b0;
        pix_sof       = 1'b0;
        frame_release = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One pixel, presented until accepted (bounded wait on pix_ready).
    task automatic send_pix(input logic [7:0] data, input logic sof);
        int n;
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_data  = data;
        n = 0;
        while (!pix_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("ready_timeout", 16'(pix_ready), 16'd1);
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] key, input int n, input logic sof_first);
        for (int i = 0; i < n; i++) send_pix(8'(i) ^ key, (i == 0) && sof_first);
    endtask

    task automatic release_pulse();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
    endtask

    initial begin
        // 1: reset values, single frame, avail latency, bias reads
        do_reset();
        check("rst_ready", 16'(pix_ready), 16'd1);
        check("rst_avail", 16'(frame_avail), 16'd0);
        check("rst_drop", 16'(drop_cnt), 16'd0);
        send_frame(8'h00, 255, 1'b1);
        check("t1_avail_before_last", 16'(frame_avail), 16'd0);
        send_pix(8'hFF, 1'b0);
        check("t1_avail_after_last", 16'(frame_avail), 16'd1);
        rd_check("t1_rd5", 9'h005, 8'h05);
        rd_check("t1_rd255", 9'h0FF, 8'hFF);
        rd_check("t1_rd_bias", 9'h100, 8'hFF);
        rd_check("t1_rd_bias_max", 9'h1FF, 8'hFF);
        release_pulse();
        check("t1_avail_released", 16'(frame_avail), 16'd0);

        // 2: unsynced pixels are discarded
        do_reset();
        for (int i = 0; i < 10; i++) send_pix(8'hAA, 1'b0);
        check("t2_avail_unsynced", 16'(frame_avail), 16'd0);
        send_frame(8'h3C, 255, 1'b1);
        check("t2_avail_before_last", 16'(frame_avail), 16'd0);
        send_pix(8'hFF ^ 8'h3C, 1'b0);
        check("t2_avail", 16'(frame_avail), 16'd1);
        rd_check("t2_rd0", 9'h000, 8'h3C);
        rd_check("t2_rd1", 9'h001, 8'h3D);
        rd_check("t2_rd10", 9'h00A, 8'h36);

        // 3: both banks full stalls the stream; release frees a bank next cycle
        do_reset();
        send_frame(8'h11, 256, 1'b1);
        send_frame(8'h22, 256, 1'b1);
        check("t3_ready_full", 16'(pix_ready), 16'd0);
        check("t3_avail", 16'(frame_avail), 16'd1);
        rd_check("t3_rd7_f1", 9'h007, 8'h16);
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        pix_data  = 8'h55;
        tick();
        tick();
        tick();
        check("t3_ready_stall", 16'(pix_ready), 16'd0);
        rd_check("t3_rd7_stall", 9'h007, 8'h16);
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        pix_valid     = 1'b0;
        pix_sof       = 1'b0;
        check("t3_ready_after_rel", 16'(pix_ready), 16'd1);
        check("t3_avail_after_rel", 16'(frame_avail), 16'd1);
        rd_check("t3_rd7_f2", 9'h007, 8'h25);
        rd_check("t3_rd0_f2", 9'h000, 8'h22);

        // 4: sof mid-frame drops the partial frame; drop count saturates
        do_reset();
        send_frame(8'h40, 100, 1'b1);
        check("t4_drop0", 16'(drop_cnt), 16'd0);
        send_frame(8'h80, 256, 1'b1);
        check("t4_drop1", 16'(drop_cnt), 16'd1);
        check("t4_avail", 16'(frame_avail), 16'd1);
        rd_check("t4_rd0", 9'h000, 8'h80);
        rd_check("t4_rd99", 9'h063, 8'hE3);
        rd_check("t4_rd150", 9'h096, 8'h16);
        release_pulse();
        for (int i = 0; i < 10; i++) send_pix(8'h01, 1'b1);
        check("t4_drop10", 16'(drop_cnt), 16'd10);
        for (int i = 0; i < 290; i++) send_pix(8'h01, 1'b1);
        check("t4_drop_sat", 16'(drop_cnt), 16'd255);

        // 5: release coinciding with completion of the other bank; idle release ignored
        do_reset();
        send_frame(8'h01, 256, 1'b1);
        send_frame(8'h02, 255, 1'b1);
        rd_check("t5_rd3_fA", 9'h003, 8'h02);
        frame_release = 1'b1;
        send_pix(8'hFF ^ 8'h02, 1'b0);
        frame_release = 1'b0;
        check("t5_avail", 16'(frame_avail), 16'd1);
        check("t5_ready", 16'(pix_ready), 16'd1);
        rd_check("t5_rd3_fB", 9'h003, 8'h01);
        rd_check("t5_rd255_fB", 9'h0FF, 8'hFD);
        release_pulse();
        check("t5_avail_empty", 16'(frame_avail), 16'd0);
        release_pulse();
        check("t5_idle_rel_avail", 16'(frame_avail), 16'd0);
        check("t5_idle_rel_ready", 16'(pix_ready), 16'd1);
        send_frame(8'h5A, 256, 1'b1);
        check("t5_avail_next", 16'(frame_avail), 16'd1);
        rd_check("t5_rd2_next", 9'h002, 8'h58);

        // 6: asynchronous reset mid-frame while a frame is available
        do_reset();
        send_frame(8'h04, 5, 1'b1);
        send_frame(8'h07, 256, 1'b1);
        check("t6_drop_pre", 16'(drop_cnt), 16'd1);
        send_frame(8'h09, 128, 1'b1);
        check("t6_avail_pre", 16'(frame_avail), 16'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_avail", 16'(frame_avail), 16'd0);
        check("t6_rst_ready", 16'(pix_ready), 16'd1);
        check("t6_rst_drop", 16'(drop_cnt), 16'd0);
        tick();
        reset = 1'b0;
        tick();
        send_frame(8'h33, 256, 1'b1);
        check("t6_avail_after", 16'(frame_avail), 16'd1);
        check("t6_drop_after", 16'(drop_cnt), 16'd0);
        rd_check("t6_rd128", 9'h080, 8'hB3);
        rd_check("t6_rd0", 9'h000, 8'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
